// File: rtl/sync_nd_filt_pkg.sv
// Shared limits and helpers for the parametrised multi-bit synchroniser.
package sync_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned SYNC_FILT_MAX   = 255;

  // Counter width able to hold 0..filt; at least one bit.
  function automatic int unsigned sync_cnt_width(input int unsigned filt);
    return (filt == 0) ? 1 : $clog2(filt + 1);
  endfunction

endpackage

// File: rtl/sync_bit_filt.sv
// One synchronised bit: flop chain, optional stability filter and edge decode.
module sync_bit_filt
  import sync_pkg::*;
#(
  parameter int unsigned STAGES  = 3,
  parameter int unsigned FILT    = 0,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic q_rise,
  output logic q_fall
);

  (* preserve, dont_retime, no_scan_reorder *)
  logic [STAGES-1:0] r_sync;
  logic              w_s;
  logic              w_q;
  logic              r_q_prev;

  // Pure flop chain: nothing may sit between d and the first stage or between stages.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign w_s = r_sync[STAGES-1];

  generate
    if (FILT == 0) begin : g_nofilt
      assign w_q = w_s;
    end else begin : g_filt
      localparam int unsigned CNT_W = sync_cnt_width(FILT);

      logic             r_q;
      logic [CNT_W-1:0] r_cnt;

      // q follows s only after FILT consecutive disagreeing samples.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_q   <= RST_VAL;
          r_cnt <= '0;
        end else if (w_s == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(FILT - 1)) begin
          r_q   <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_q = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q_prev <= RST_VAL;
    end else begin
      r_q_prev <= w_q;
    end
  end

  assign q      = w_q;
  assign q_rise = w_q & ~r_q_prev;
  assign q_fall = ~w_q & r_q_prev;

endmodule

// File: rtl/sync_nd_filt.sv
// Bank of WIDTH independent synchronisers with optional glitch filter and edge pulses.
module sync_nd_filt
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      STAGES  = 3,
  parameter int unsigned      FILT    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  if (WIDTH == 0 || WIDTH > 64) begin : g_chk_width
    $error("sync_nd_filt: WIDTH must be 1..64");
  end
  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_chk_stages
    $error("sync_nd_filt: STAGES out of range");
  end
  if (FILT > SYNC_FILT_MAX) begin : g_chk_filt
    $error("sync_nd_filt: FILT out of range");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sync_bit_filt #(
      .STAGES  (STAGES),
      .FILT    (FILT),
      .RST_VAL (RST_VAL[gi])
    ) u_bit (
      .clk    (clk),
      .rstn   (rstn),
      .d      (d[gi]),
      .q      (q[gi]),
      .q_rise (q_rise[gi]),
      .q_fall (q_fall[gi])
    );
  end

endmodule

// File: tb/tb_sync_nd_filt.sv
// Scoreboarded bench: five configurations checked every cycle against a history-based model.
module tb_sync_nd_filt;

  localparam int NI = 5;
  localparam int HL = 16;
  localparam int          STG  [NI] = '{3, 2, 4, 2, 4};
  localparam int          FLT  [NI] = '{0, 4, 8, 0, 0};
  localparam logic [15:0] RSTV [NI] = '{16'h00A5, 16'h0000, 16'h0003, 16'h0000, 16'h0005};
  localparam logic [15:0] MSK  [NI] = '{16'h00FF, 16'hFFFF, 16'h000F, 16'h000F, 16'h000F};

  logic clk;
  logic rstn;
  logic [7:0]  d_a, q_a, qr_a, qf_a;
  logic [15:0] d_b, q_b, qr_b, qf_b;
  logic [3:0]  d_c, q_c, qr_c, qf_c;
  logic [3:0]  d_d, q_d, qr_d, qf_d;
  logic [3:0]  d_e, q_e, qr_e, qf_e;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] hist [NI][HL];
  logic [15:0] qm   [NI];
  logic [15:0] qpm  [NI];
  logic [15:0] m_nq;
  logic        m_flip;
  logic [47:0] sb_q [$];
  logic [47:0] c_obs, c_exp;

  sync_nd_filt #(.WIDTH(8),  .STAGES(3), .FILT(0), .RST_VAL(8'hA5)) u_a (
    .clk(clk), .rstn(rstn), .d(d_a), .q(q_a), .q_rise(qr_a), .q_fall(qf_a));
  sync_nd_filt #(.WIDTH(16), .STAGES(2), .FILT(4), .RST_VAL(16'h0000)) u_b (
    .clk(clk), .rstn(rstn), .d(d_b), .q(q_b), .q_rise(qr_b), .q_fall(qf_b));
  sync_nd_filt #(.WIDTH(4),  .STAGES(4), .FILT(8), .RST_VAL(4'h3)) u_c (
    .clk(clk), .rstn(rstn), .d(d_c), .q(q_c), .q_rise(qr_c), .q_fall(qf_c));
  sync_nd_filt #(.WIDTH(4),  .STAGES(2), .FILT(0), .RST_VAL(4'h0)) u_d (
    .clk(clk), .rstn(rstn), .d(d_d), .q(q_d), .q_rise(qr_d), .q_fall(qf_d));
  sync_nd_filt #(.WIDTH(4),  .STAGES(4), .FILT(0), .RST_VAL(4'h5)) u_e (
    .clk(clk), .rstn(rstn), .d(d_e), .q(q_e), .q_rise(qr_e), .q_fall(qf_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] din(input int k);
    case (k)
      0:       return 16'(d_a);
      1:       return d_b;
      2:       return 16'(d_c);
      3:       return 16'(d_d);
      default: return 16'(d_e);
    endcase
  endfunction

  function automatic logic [47:0] obs(input int k);
    case (k)
      0:       return {16'(q_a), 16'(qr_a), 16'(qf_a)};
      1:       return {q_b, qr_b, qf_b};
      2:       return {16'(q_c), 16'(qr_c), 16'(qf_c)};
      3:       return {16'(q_d), 16'(qr_d), 16'(qf_d)};
      default: return {16'(q_e), 16'(qr_e), 16'(qf_e)};
    endcase
  endfunction

  // Model: s is the d sampled STAGES-1 edges ago; a filtered bit flips once the
  // last FILT samples seen by the filter all disagree with the current q.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rstn) begin
        for (int j = 0; j < HL; j++) hist[k][j] = RSTV[k];
        qm[k]  = RSTV[k];
        qpm[k] = RSTV[k];
      end else begin
        for (int j = HL - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = din(k) & MSK[k];
        qpm[k] = qm[k];
        m_nq   = qm[k];
        if (FLT[k] == 0) begin
          m_nq = hist[k][STG[k]-1];
        end else begin
          for (int b = 0; b < 16; b++) begin
            m_flip = 1'b1;
            for (int i = 0; i < FLT[k]; i++)
              if (hist[k][STG[k]+i][b] == qm[k][b]) m_flip = 1'b0;
            if (m_flip) m_nq[b] = ~qm[k][b];
          end
        end
        qm[k] = m_nq & MSK[k];
      end
      sb_q.push_back({qm[k], qm[k] & ~qpm[k], ~qm[k] & qpm[k]});
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("sb_depth%0d", k), 16'(sb_q.size()), 16'(NI - k));
      if (sb_q.size() != 0) begin
        c_exp = sb_q.pop_front();
        c_obs = obs(k);
        chk($sformatf("q%0d", k),    c_obs[47:32], c_exp[47:32]);
        chk($sformatf("rise%0d", k), c_obs[31:16], c_exp[31:16]);
        chk($sformatf("fall%0d", k), c_obs[15:0],  c_exp[15:0]);
        chk($sformatf("ovl%0d", k),  c_obs[31:16] & c_obs[15:0], 16'h0);
      end
    end
  end

  int n, lat_a, lat_d, lat_e;
  int r0, r1, f1, h1, r2, rt2;

  initial begin
    rstn = 1'b0;
    d_a = '0; d_b = '0; d_c = '0; d_d = '0; d_e = '0;

    // Reset values hold while rstn is low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_q", 16'(q_a), 16'h00A5);
      chk("rst_edge", 16'({qr_a, qf_a}), 16'h0);
    end
    @(negedge clk); rstn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) chk("rel_edge", 16'({qr_a, qf_a}), 16'h0);
    end while (q_a == 8'hA5 && n < 30);
    chk("rel_lat", 16'(n), 16'd3);
    chk("rel_q", 16'(q_a), 16'h0000);
    chk("rel_fall", 16'(qf_a), 16'h00A5);
    @(posedge clk); #1;
    chk("rel_fall_1cyc", 16'(qf_a), 16'h0);

    // Unfiltered latency equals STAGES for 2, 3 and 4 stages.
    repeat (6) @(negedge clk);
    d_a = 8'h01; d_d = 4'h1; d_e = 4'h2;
    lat_a = 0; lat_d = 0; lat_e = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (lat_a == 0 && q_a[0]) lat_a = i;
      if (lat_d == 0 && q_d[0]) lat_d = i;
      if (lat_e == 0 && q_e[1]) lat_e = i;
    end
    chk("lat_s3", 16'(lat_a), 16'd3);
    chk("lat_s2", 16'(lat_d), 16'd2);
    chk("lat_s4", 16'(lat_e), 16'd4);

    // Glitch filter FILT=4: bit0 3-cycle pulse, bit1 4-cycle pulse, bit2 restart.
    r0 = 0; r1 = 0; f1 = 0; h1 = 0; r2 = 0; rt2 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      d_b = {13'h0,
             (i >= 1 && i < 4) || (i >= 5 && i < 9),
             (i >= 1 && i < 5),
             (i >= 1 && i < 4)};
      @(posedge clk); #1;
      r0 += int'(qr_b[0] | q_b[0]);
      r1 += int'(qr_b[1]);
      f1 += int'(qf_b[1]);
      h1 += int'(q_b[1]);
      r2 += int'(qr_b[2]);
      if (qr_b[2]) rt2 = i;
    end
    chk("glitch3_rej", 16'(r0), 16'd0);
    chk("pulse4_rise", 16'(r1), 16'd1);
    chk("pulse4_fall", 16'(f1), 16'd1);
    chk("pulse4_high", 16'(h1), 16'd4);
    chk("restart_rise", 16'(r2), 16'd1);
    chk("restart_when", 16'(rt2), 16'd10);

    // Reset mid-count on FILT=8: count reaches 5 after 9 edges, then reset.
    @(negedge clk); d_c = 4'hF;
    repeat (9) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_q", 16'(q_c), 16'h0003);
    end
    @(negedge clk); rstn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (q_c == 4'h3 && n < 40);
    chk("midrst_lat", 16'(n), 16'd12);
    chk("midrst_rise", 16'(qr_c), 16'h000C);

    // Random independent toggles with jittered drive times.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #($urandom_range(0, 3));
      d_a ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
      d_b ^= 16'($urandom) & 16'($urandom) & 16'($urandom);
      d_c ^= 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      d_d ^= 4'($urandom) & 4'($urandom);
      d_e ^= 4'($urandom) & 4'($urandom);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_nd_filt.md
# sync_nd_filt

Parametrised multi-bit synchroniser with an optional glitch filter and per-bit edge-pulse outputs. It is the configurable successor to the fixed three-stage single-bit synchroniser cell. It carries quasi-static control and status bits (interrupt lines, power and clock-enable requests, config strobes) from any foreign domain into the `clk` domain. Each bit is independent; multi-bit values that must stay coherent are out of scope and use a handshake or FIFO crossing.

## Interface
- `WIDTH`, default 1: number of independent bits, 1..64.
- `STAGES`, default 3: synchroniser flop depth, 2..4.
- `FILT`, default 0: stability cycles required before `q` changes, 0..255; 0 disables the filter.
- `RST_VAL`, default all zeros: per-bit reset value, `WIDTH` bits.
- `clk` input, 1: destination-domain clock; the only clock.
- `rstn` input, 1: reset, synchronous and active-low.
- `d` input, `WIDTH`: asynchronous inputs; no timing relation to `clk`.
- `q` output, `WIDTH`: synchronised and filtered level.
- `q_rise` output, `WIDTH`: one-cycle pulse when `q` goes 0->1.
- `q_fall` output, `WIDTH`: one-cycle pulse when `q` goes 1->0.

## Operation
- **Sync chain.** Per bit, `STAGES` flops clocked on `clk`: `s1 <= d`, `s2 <= s1`, and so on. `s` is the last stage.
- **FILT = 0.** `q = s` directly; no counter is built.
- **FILT > 0.** Per bit, a registered `q` and a counter `cnt` of width `clog2(FILT+1)`. Each cycle:
  - if `s == q`: `cnt <= 0`;
  - else if `cnt == FILT-1`: `q <= s` and `cnt <= 0`;
  - else: `cnt <= cnt + 1`.
  - Net effect: `q` follows `s` only after `FILT` consecutive samples of `s != q`.
  - Any sample with `s == q` restarts the count. No saturation or wrap is possible.
- **Edge pulses.** `q_prev <= q` each cycle. `q_rise = q & ~q_prev`, `q_fall = ~q & q_prev`, decoded combinationally from flops. At most one of the two is high per bit per cycle.
- **Reset.** While `rstn` is low at a `clk` edge:
  - all sync stages, `q` and `q_prev` load `RST_VAL`; `cnt` loads 0;
  - `q_rise` and `q_fall` are 0 throughout reset and in the first cycle after it, because `q == q_prev`.
- **Reset mid-count.** The partial count is discarded; filtering restarts from 0 after release.
- **Reset release with `d != RST_VAL`.** Treated as a normal transition: it is seen after the full latency and produces one edge pulse.
- **Physical requirements.**
  - Sync-chain flops are marked preserve / no-retime / no-scan-reorder for synthesis.
  - No logic is allowed between `d` and `s1`, or between sync stages.

## Timing
- Let `d` change and be captured by `s1` at edge E0. With a metastability resolution window, capture happens at E0 or E0+1.
- `s` changes at edge E0+STAGES-1.
- **FILT = 0:** `q` changes at E0+STAGES-1, i.e. `STAGES` edges from capture.
- **FILT = N:** `q` changes at E0+STAGES-1+N, provided `d` stayed stable long enough for `s` to hold N samples.
- Edge pulses are high for exactly the first cycle of the new `q` value.
- **Rejection:** an input pulse shorter than `FILT` `clk` cycles, as seen at `s`, is never propagated to `q`.
- **Acceptance:** an input held for at least `FILT+1` cycles is always propagated.
- Throughput: one filtered transition per bit at most every `FILT` cycles, or every cycle when `FILT = 0`.

## Structure
- Package `sync_pkg` holds:
  - `SYNC_STAGES_MIN = 2` and `SYNC_STAGES_MAX = 4`;
  - `SYNC_FILT_MAX = 255`;
  - a function returning the counter width for a given `FILT`.
- Parameter range checks are elaboration-time assertions against these constants.
- One sub-module, `sync_bit_filt`, holds the per-bit chain, filter and edge detect. The top instantiates `WIDTH` copies in a generate loop, each with its own `RST_VAL` bit.

## Test plan
- **Reset values:** `WIDTH=8`, `RST_VAL=8'hA5`, `rstn` low for 3 cycles with `d=8'h00` -> `q=8'hA5` and `q_rise=q_fall=0` during reset and in the first cycle after release; `q` reaches `8'h00` after `STAGES` edges, with `q_fall=8'hA5` for exactly one cycle.
- **Latency:** `STAGES=3`, `FILT=0`, `d` 0->1 setup-clean before edge E0 -> `q=1` after E0+2; `q_rise` high for one cycle. Repeat with `STAGES=2` and `4`.
- **Glitch filter:** `STAGES=2`, `FILT=4`. A 3-cycle `d` high pulse -> `q` stays 0 and no pulses. A 4-cycle pulse -> `q` high for exactly 4 cycles, with one `q_rise` and one `q_fall`.
- **Count restart:** `FILT=4`, `d` high 3 cycles, low 1 cycle, high 4 cycles -> `q` rises only at the end of the second high run (4 cycles after it reaches `s`).
- **Reset mid-count:** `FILT=8`, assert `rstn` low when `cnt=5` -> `cnt=0` and `q=RST_VAL`. After release with `d` steady, `q` changes after `STAGES+8` edges, not sooner.
- **Independent bits:** `WIDTH=16`, random asynchronous toggles with jittered `d` timing against `clk` -> per-bit scoreboard matches the reference model within ±1 cycle capture uncertainty; edge pulses never overlap on the same bit.
